// File: rtl/gdma_pkg.sv
// Shared types and constants for the GDMA read-data channel.
package gdma_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_HDR0,
    ST_HDR1,
    ST_DATA,
    ST_DRAIN
  } state_t;

  // A burst may not cross a 4 KiB page: word address low bits all ones ends it.
  localparam logic [9:0] MASK_4K   = 10'h3FF;
  // Longest AXI4 INCR burst is 256 beats; burst counter value 255 ends it.
  localparam logic [7:0] MAX_BURST = 8'hFF;
  localparam logic [1:0] RESP_OKAY = 2'b00;
  localparam int         HDR_WORDS = 2;

endpackage

// File: rtl/gdma_rdata_fifo.sv
// First-word-fall-through FIFO for read beats ({tlast, data}); flush empties it.
module gdma_rdata_fifo #(
  parameter int DEPTH = 16,
  parameter int WIDTH = 33
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;

  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign rdata = mem[rd_ptr[AW-1:0]];

  // Pointer update; a push into a full FIFO is dropped even if a pop happens too.
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push && !full) wr_ptr <= wr_ptr + (AW+1)'(1);
      if (pop && !empty) rd_ptr <= rd_ptr + (AW+1)'(1);
    end
  end

  // Storage write; contents need no reset because the pointers qualify them.
  always_ff @(posedge clk) begin
    if (push && !full) mem[wr_ptr[AW-1:0]] <= wdata;
  end

endmodule

// File: rtl/gdma_rdata.sv
// GDMA read-data channel: checks AXI R framing, buffers beats, and streams
// two header words followed by the payload toward the GTP link.
//
// state | meaning
// IDLE  | no transfer, gdma_done held high
// HDR0  | sending start_addr[31:0]; R beats may already fill the FIFO
// HDR1  | sending length
// DATA  | streaming FIFO head while beats are still arriving
// DRAIN | all beats received; emptying FIFO, waiting for gdma_addr_done
module gdma_rdata
  import gdma_pkg::*;
#(
  parameter int FIFO_DEPTH = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [48:0] start_addr,
  input  logic [31:0] length,
  input  logic        op_start,
  input  logic        gdma_addr_done,
  output logic        gdma_done,
  output logic        rd_err,
  input  logic [31:0] gdma_ddr_rdata,
  input  logic [1:0]  gdma_ddr_rresp,
  input  logic        gdma_ddr_rlast,
  input  logic        gdma_ddr_rvalid,
  output logic        gdma_ddr_rready,
  output logic        gdma2gtp_tvalid,
  input  logic        gdma2gtp_tready,
  output logic [31:0] gdma2gtp_tdata,
  output logic        gdma2gtp_tlast
);

  // The FIFO must at least cover the header phase twice over and be a power of two.
  if (FIFO_DEPTH < 2 * HDR_WORDS || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
    $error("gdma_rdata: FIFO_DEPTH must be a power of two and at least 4");
  end

  state_t      state_q, state_d;
  logic [31:0] hdr0_q;
  logic [31:0] len_q;
  logic [46:0] raddr_cnt;
  logic [7:0]  burst_cnt;
  logic [29:0] rbeat_cnt;
  logic        rdata_done;
  logic        tlast_done_q;
  logic        done_set;

  logic [32:0] fifo_rdata;
  logic        fifo_full;
  logic        fifo_empty;
  logic        fifo_pop;

  logic r_hs;
  logic final_beat;
  logic exp_last;
  logic all_rcvd;
  logic tlast_hs;

  assign r_hs       = gdma_ddr_rvalid && gdma_ddr_rready;
  assign final_beat = (rbeat_cnt == len_q[31:2]);
  assign exp_last   = (raddr_cnt[9:0] == MASK_4K) || (burst_cnt == MAX_BURST) || final_beat;
  assign all_rcvd   = rdata_done || (r_hs && final_beat);

  // rready depends only on registered state, never on tready.
  assign gdma_ddr_rready = !fifo_full && !rdata_done &&
                           (state_q == ST_HDR0 || state_q == ST_HDR1 || state_q == ST_DATA);

  assign fifo_pop = gdma2gtp_tvalid && gdma2gtp_tready &&
                    (state_q == ST_DATA || state_q == ST_DRAIN);
  assign tlast_hs = fifo_pop && fifo_rdata[32];

  gdma_rdata_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (33)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .flush (op_start),
    .push  (r_hs && !op_start),
    .wdata ({final_beat, gdma_ddr_rdata}),
    .pop   (fifo_pop),
    .rdata (fifo_rdata),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  // Next state and stream mux. The tlast entry is the last one written, so
  // popping it (or having popped it earlier) means the FIFO is drained.
  // When every beat arrived during the header, HDR1 skips straight to DRAIN
  // so the tlast word is only ever presented in DRAIN.
  always_comb begin
    state_d         = state_q;
    done_set        = 1'b0;
    gdma2gtp_tvalid = 1'b0;
    gdma2gtp_tdata  = 32'h0;
    gdma2gtp_tlast  = 1'b0;
    unique case (state_q)
      ST_HDR0: begin
        gdma2gtp_tvalid = 1'b1;
        gdma2gtp_tdata  = hdr0_q;
        if (gdma2gtp_tready) state_d = ST_HDR1;
      end
      ST_HDR1: begin
        gdma2gtp_tvalid = 1'b1;
        gdma2gtp_tdata  = len_q;
        if (gdma2gtp_tready) state_d = all_rcvd ? ST_DRAIN : ST_DATA;
      end
      ST_DATA, ST_DRAIN: begin
        gdma2gtp_tvalid = !fifo_empty;
        gdma2gtp_tdata  = fifo_empty ? 32'h0 : fifo_rdata[31:0];
        gdma2gtp_tlast  = !fifo_empty && fifo_rdata[32];
        if (state_q == ST_DATA) begin
          if (all_rcvd) state_d = ST_DRAIN;
        end else if ((tlast_hs || tlast_done_q) && gdma_addr_done) begin
          state_d  = ST_IDLE;
          done_set = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    if (op_start) begin
      state_d  = ST_HDR0;
      done_set = 1'b0;
    end
  end

  // Transfer bookkeeping: header latches, beat counters, error and done flags.
  always_ff @(posedge clk) begin
    if (rst) begin
      hdr0_q       <= 32'h0;
      len_q        <= 32'h0;
      raddr_cnt    <= '0;
      burst_cnt    <= '0;
      rbeat_cnt    <= '0;
      rdata_done   <= 1'b0;
      tlast_done_q <= 1'b0;
      rd_err       <= 1'b0;
      gdma_done    <= 1'b1;
    end else if (op_start) begin
      hdr0_q       <= start_addr[31:0];
      len_q        <= length;
      raddr_cnt    <= start_addr[48:2];
      burst_cnt    <= '0;
      rbeat_cnt    <= '0;
      rdata_done   <= 1'b0;
      tlast_done_q <= 1'b0;
      rd_err       <= 1'b0;
      gdma_done    <= 1'b0;
    end else begin
      if (r_hs) begin
        raddr_cnt <= raddr_cnt + 47'd1;
        rbeat_cnt <= rbeat_cnt + 30'd1;
        burst_cnt <= exp_last ? 8'h00 : burst_cnt + 8'd1;
        if (final_beat) rdata_done <= 1'b1;
        if (gdma_ddr_rresp != RESP_OKAY || gdma_ddr_rlast != exp_last) rd_err <= 1'b1;
      end
      if (tlast_hs) tlast_done_q <= 1'b1;
      if (done_set) gdma_done <= 1'b1;
    end
  end

endmodule

// File: tb/tb_gdma_rdata.sv
// Self-checking bench for gdma_rdata: table of directed transfers, random
// transfers against a behavioural stream model, plus abort and reset sequences.
module tb_gdma_rdata;

  localparam int DEPTH = 16;

  logic        clk = 1'b0;
  logic        rst;
  logic [48:0] start_addr;
  logic [31:0] length;
  logic        op_start;
  logic        gdma_addr_done;
  logic        gdma_done;
  logic        rd_err;
  logic [31:0] gdma_ddr_rdata;
  logic [1:0]  gdma_ddr_rresp;
  logic        gdma_ddr_rlast;
  logic        gdma_ddr_rvalid;
  logic        gdma_ddr_rready;
  logic        gdma2gtp_tvalid;
  logic        gdma2gtp_tready;
  logic [31:0] gdma2gtp_tdata;
  logic        gdma2gtp_tlast;

  always #5 clk = ~clk;

  gdma_rdata #(.FIFO_DEPTH(DEPTH)) dut (
    .clk             (clk),
    .rst             (rst),
    .start_addr      (start_addr),
    .length          (length),
    .op_start        (op_start),
    .gdma_addr_done  (gdma_addr_done),
    .gdma_done       (gdma_done),
    .rd_err          (rd_err),
    .gdma_ddr_rdata  (gdma_ddr_rdata),
    .gdma_ddr_rresp  (gdma_ddr_rresp),
    .gdma_ddr_rlast  (gdma_ddr_rlast),
    .gdma_ddr_rvalid (gdma_ddr_rvalid),
    .gdma_ddr_rready (gdma_ddr_rready),
    .gdma2gtp_tvalid (gdma2gtp_tvalid),
    .gdma2gtp_tready (gdma2gtp_tready),
    .gdma2gtp_tdata  (gdma2gtp_tdata),
    .gdma2gtp_tlast  (gdma2gtp_tlast)
  );

  int checks   = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // tr_mode: 0 tready always high, 1 high one cycle in four, 2 random.
  typedef struct {
    logic [48:0] addr;
    logic [31:0] len;
    int          tr_mode;
    int          rv_pct;
    int          omit_last;
    int          err_beat;
    bit          late;
    bit          inc;
    bit          exp_err;
    int          exp_done;
  } xfer_t;

  xfer_t tbl[10];

  task automatic run_xfer(input xfer_t x, input string tag);
    int          n, pos, bi, wi, occ, cyc, budget, t_cyc, a_cyc, done_cyc, exp_dc;
    longint      a0;
    logic        el, r_hs, s_hs, prev_stall;
    logic [32:0] prev_word;
    logic [32:0] exp_q[$];
    logic [31:0] bd[$];
    logic        bl[$];
    logic [1:0]  br[$];

    // Reference model: expected rlast from page/burst/length rules on word addresses.
    n   = int'(x.len[31:2]) + 1;
    a0  = longint'(x.addr[48:2]);
    pos = 0;
    exp_q.push_back({1'b0, x.addr[31:0]});
    exp_q.push_back({1'b0, x.len});
    for (int i = 0; i < n; i++) begin
      el  = (((a0 + i) % 1024) == 1023) || (pos == 255) || (i == n - 1);
      pos = el ? 0 : pos + 1;
      bd.push_back(x.inc ? 32'(i + 1) : $urandom);
      bl.push_back((i == x.omit_last) ? 1'b0 : el);
      br.push_back((i == x.err_beat) ? 2'b10 : 2'b00);
      exp_q.push_back({(i == n - 1), bd[i]});
    end

    @(posedge clk); #1;
    start_addr      = x.addr;
    length          = x.len;
    op_start        = 1'b1;
    gdma_ddr_rvalid = 1'b0;
    gdma_addr_done  = 1'b0;
    gdma2gtp_tready = 1'b0;
    @(posedge clk); #1;
    op_start   = 1'b0;
    cyc        = 1;
    bi         = 0;
    wi         = 0;
    occ        = 0;
    t_cyc      = -1;
    a_cyc      = -1;
    done_cyc   = -1;
    prev_stall = 1'b0;
    prev_word  = '0;
    budget     = 12 * n + 100;

    while (done_cyc < 0 && cyc < budget) begin
      case (x.tr_mode)
        0:       gdma2gtp_tready = 1'b1;
        1:       gdma2gtp_tready = (cyc % 4 == 0);
        default: gdma2gtp_tready = 1'($urandom_range(0, 1));
      endcase
      if (!gdma_addr_done && (x.late ? (t_cyc >= 0 && cyc >= t_cyc + 10) : cyc >= 2)) begin
        gdma_addr_done = 1'b1;
        a_cyc          = cyc;
      end
      if (!gdma_ddr_rvalid && bi < n && $urandom_range(1, 100) <= x.rv_pct) begin
        gdma_ddr_rvalid = 1'b1;
        gdma_ddr_rdata  = bd[bi];
        gdma_ddr_rlast  = bl[bi];
        gdma_ddr_rresp  = br[bi];
      end

      @(negedge clk);
      if (cyc == 1) begin
        chk({tag, "_hdr0_valid"}, gdma2gtp_tvalid, 1'b1);
        chk({tag, "_hdr0_data"}, gdma2gtp_tdata, x.addr[31:0]);
        chk({tag, "_err_cleared"}, rd_err, 1'b0);
        chk({tag, "_busy"}, gdma_done, 1'b0);
      end
      if (occ == DEPTH) chk({tag, "_rready_full"}, gdma_ddr_rready, 1'b0);
      if (prev_stall) chk({tag, "_hold"}, {gdma2gtp_tvalid, gdma2gtp_tlast, gdma2gtp_tdata}, {1'b1, prev_word});
      r_hs = gdma_ddr_rvalid && gdma_ddr_rready;
      s_hs = gdma2gtp_tvalid && gdma2gtp_tready;
      if (gdma_done) done_cyc = cyc;
      if (s_hs) begin
        if (wi < exp_q.size()) begin
          chk($sformatf("%s_word%0d", tag, wi), {gdma2gtp_tlast, gdma2gtp_tdata}, exp_q[wi]);
          if (exp_q[wi][32]) t_cyc = cyc;
        end else begin
          checks++;
          failures++;
          $display("FAIL %s_extra_word: got 0x%0h, expected no more words", tag, gdma2gtp_tdata);
        end
        if (wi >= 2) occ--;
        wi++;
      end
      if (r_hs) begin
        occ++;
        bi++;
      end
      prev_stall = gdma2gtp_tvalid && !gdma2gtp_tready;
      prev_word  = {gdma2gtp_tlast, gdma2gtp_tdata};

      @(posedge clk); #1;
      if (r_hs) gdma_ddr_rvalid = 1'b0;
      cyc++;
    end

    if (done_cyc < 0) begin
      checks++;
      failures++;
      $display("FAIL %s_timeout: gdma_done not seen after %0d cycles, words %0d of %0d", tag, cyc, wi, exp_q.size());
    end else begin
      exp_dc = ((t_cyc > a_cyc) ? t_cyc : a_cyc) + 1;
      chk({tag, "_word_count"}, wi, exp_q.size());
      chk({tag, "_done_cycle"}, done_cyc, exp_dc);
      if (x.exp_done > 0) chk({tag, "_done_exact"}, done_cyc, x.exp_done);
      chk({tag, "_rd_err"}, rd_err, x.exp_err);
    end

    gdma_ddr_rvalid = 1'b0;
    gdma2gtp_tready = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk({tag, "_idle_tvalid"}, gdma2gtp_tvalid, 1'b0);
    chk({tag, "_idle_done"}, gdma_done, 1'b1);
    chk({tag, "_sticky_err"}, rd_err, x.exp_err);
  endtask

  // Starts a transfer and feeds nb beats (beat 1 with SLVERR) while the stream is stalled.
  task automatic partial(input logic [48:0] a, input logic [31:0] l, input int nb);
    @(posedge clk); #1;
    start_addr      = a;
    length          = l;
    op_start        = 1'b1;
    gdma_ddr_rvalid = 1'b0;
    gdma2gtp_tready = 1'b0;
    gdma_addr_done  = 1'b0;
    @(posedge clk); #1;
    op_start = 1'b0;
    for (int i = 0; i < nb; i++) begin
      gdma_ddr_rvalid = 1'b1;
      gdma_ddr_rdata  = 32'hDEAD_0000 + 32'(i);
      gdma_ddr_rresp  = (i == 1) ? 2'b10 : 2'b00;
      gdma_ddr_rlast  = 1'b0;
      @(posedge clk); #1;
    end
    gdma_ddr_rvalid = 1'b0;
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_done"}, gdma_done, 1'b1);
    chk({tag, "_rd_err"}, rd_err, 1'b0);
    chk({tag, "_rready"}, gdma_ddr_rready, 1'b0);
    chk({tag, "_tvalid"}, gdma2gtp_tvalid, 1'b0);
    chk({tag, "_tlast"}, gdma2gtp_tlast, 1'b0);
    chk({tag, "_tdata"}, gdma2gtp_tdata, 32'h0);
  endtask

  initial begin
    xfer_t rx;

    rst             = 1'b1;
    start_addr      = '0;
    length          = '0;
    op_start        = 1'b0;
    gdma_addr_done  = 1'b0;
    gdma_ddr_rdata  = '0;
    gdma_ddr_rresp  = '0;
    gdma_ddr_rlast  = 1'b0;
    gdma_ddr_rvalid = 1'b0;
    gdma2gtp_tready = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk_reset_outputs("reset");

    //            addr                   len         tr  rv%  omit err late inc err done
    tbl[0] = '{49'h1000,            32'h3C,       0, 100, -1, -1, 0, 1, 0, 19};
    tbl[1] = '{49'hFF8,             32'h0C,       0, 100, -1, -1, 0, 0, 0, 0};
    tbl[2] = '{49'hFF8,             32'h0C,       0, 100,  1, -1, 0, 0, 1, 0};
    tbl[3] = '{49'h2000,            32'hFC,       1, 100, -1, -1, 0, 0, 0, 0};
    tbl[4] = '{49'h3000,            32'h1C,       2,  70, -1,  2, 0, 0, 1, 0};
    tbl[5] = '{49'h4000,            32'h1C,       0, 100, -1, -1, 1, 0, 0, 0};
    tbl[6] = '{49'h10,              32'h3,        0, 100, -1, -1, 0, 0, 0, 4};
    tbl[7] = '{49'h1_FFFF_FFFF_FFFC, 32'h0C,      2,  80, -1, -1, 0, 0, 0, 0};
    tbl[8] = '{49'h0,               32'd1196,     0,  50, -1, -1, 0, 0, 0, 0};
    tbl[9] = '{49'h800,             32'h0,        0, 100, -1, -1, 0, 0, 0, 4};

    for (int i = 0; i < 10; i++) run_xfer(tbl[i], $sformatf("t%0d", i));

    for (int i = 0; i < 8; i++) begin
      rx.addr      = 49'({$urandom, $urandom});
      rx.len       = 32'(($urandom_range(0, 79) << 2) | $urandom_range(0, 3));
      rx.tr_mode   = $urandom_range(0, 2);
      rx.rv_pct    = $urandom_range(30, 100);
      rx.omit_last = -1;
      rx.err_beat  = -1;
      rx.late      = 1'b0;
      rx.inc       = 1'b0;
      rx.exp_err   = 1'b0;
      rx.exp_done  = 0;
      run_xfer(rx, $sformatf("r%0d", i));
    end

    // Abort: a second op_start mid-transfer flushes the stale beats and clears rd_err.
    partial(49'h5000, 32'h7C, 6);
    @(negedge clk);
    chk("abort_pre_err", rd_err, 1'b1);
    chk("abort_pre_busy", gdma_done, 1'b0);
    run_xfer(tbl[3], "abort");

    // Synchronous reset mid-transfer returns every output to its reset value.
    partial(49'h6000, 32'h7C, 5);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk_reset_outputs("midrst");
    run_xfer(tbl[1], "postrst");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
